conv_scan_ctrl: RTL and testbench
=================================

# conv_scan_ctrl

Raster-scan sequencer for the convolution datapath. It walks output pixel coordinates (i, j) over the feature map and pulses `addr_gen` to the patch address generator directly downstream. It waits the feature-BRAM read latency, then presents a `patch_valid`/`patch_ready` handshake to the MAC stage. It sits between the layer controller (`start`/`done`) and the patch address generator / feature BRAM / MAC chain.

## Interface
- `IMG_W`, default 28: columns per row; legal range 2..32.
- `IMG_H`, default 28: rows per map; legal range 2..32.
- `RD_LAT`, default 2: cycles from the addr_gen-registered addresses to BRAM data valid; legal range 1..15.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin one full-map scan; sampled only in IDLE.
- `patch_ready`  in  1  MAC stage accepts the current patch.
- `i`  out  5  current output row, registered.
- `j`  out  5  current output column, registered.
- `addr_gen`  out  1  one-cycle strobe to the address generator; i/j are valid while it is high.
- `patch_valid`  out  1  BRAM window data for (i, j) is valid.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last patch is accepted.

## Operation
- All outputs are registered (Moore). Reset values: i=0, j=0, addr_gen=0, patch_valid=0, busy=0, done=0, state=IDLE, wait counter=0.
- States:
  - IDLE: `start`=1 -> ISSUE, with i=0 and j=0.
  - ISSUE: addr_gen=1 for exactly one cycle. Next state is PRIME if priming applies (see Configuration); otherwise WAIT, with the counter loaded to RD_LAT.
  - PRIME: addr_gen=1 for one more cycle with the same i/j -> WAIT, with the counter loaded to RD_LAT.
  - WAIT: the counter decrements each cycle. When it reaches 1 the next state is HOLD.
  - HOLD: patch_valid=1 and it stays high until `patch_ready`=1 is sampled.
- On the accepting edge in HOLD:
  - If j < IMG_W-1: j <= j+1, go to ISSUE.
  - Else if i < IMG_H-1: j <= 0, i <= i+1, go to ISSUE.
  - Else: go to DONE, with i and j held at their last values.
- DONE: done=1 for one cycle, i/j cleared to 0 -> IDLE.
- i and j change only on the accepting edge or in DONE. They are stable from ISSUE through HOLD.
- `start` outside IDLE is ignored. `patch_ready` outside HOLD is ignored.
- Row/column compares are done at 5-bit width against IMG_W-1 and IMG_H-1. No wrap past 31 is possible within the legal parameter range.

## Timing
- addr_gen is high in cycle t (in ISSUE, or in PRIME if present). patch_valid first rises at cycle t+RD_LAT+1.
- Per-position minimum: 1+RD_LAT+1 cycles when `patch_ready` is held high, plus 1 cycle on primed columns.
- patch_valid deasserts on the cycle after acceptance. It is never high in two back-to-back positions without an intervening ISSUE.
- `start` in IDLE at edge e: busy=1 and addr_gen=1 from cycle e+1.
- `done` is high the cycle after the final acceptance. busy drops together with done.
- Asynchronous reset mid-scan: all outputs return to their reset values immediately. No done is produced, and a new `start` restarts from (0,0).
- `patch_ready` high on the same edge patch_valid first rises does not count as acceptance. Acceptance requires the state to be HOLD.

## Configuration
- `CONV_SCAN_ROW_PRIME_EN` defined:
  - Priming applies when j==0, i.e. at the first column of every row including (0,0).
  - addr_gen is high for two consecutive cycles with identical i/j.
  - This lets the downstream generator register the row change before loading its full 3x3 window.
  - Latency is measured from the second strobe.
- Undefined: PRIME is never entered. Every position gets exactly one addr_gen cycle.

## Test plan
- Full scan, IMG_W=IMG_H=28, RD_LAT=2, patch_ready tied high, macro undefined:
  - Exactly 784 patch_valid acceptances in raster order (0,0)…(27,27).
  - 784 addr_gen cycles, one done pulse, total 3136 cycles from start to done.
- Same scan with macro defined:
  - 812 addr_gen cycles, with double strobes only at j=0.
  - Total 3164 cycles.
- Backpressure: hold patch_ready low for 5 cycles at (3,27).
  - patch_valid stays high and i/j stay at (3,27) for all 5 cycles.
  - On acceptance, the next addr_gen shows (4,0).
- Latency, RD_LAT=1 then RD_LAT=15: patch_valid rises exactly RD_LAT+1 cycles after the (last) addr_gen cycle.
- Reset mid-scan: assert rst low during WAIT at (10,5).
  - All outputs go to 0 asynchronously and no done is produced.
  - After start, the scan resumes at (0,0).
- start pulsed while busy at (2,2): no effect on the sequence and a single done at the end.
- IMG_W=2, IMG_H=2, ready high: exactly 4 positions, in the order (0,0), (0,1), (1,0), (1,1).

Source files
------------

// File: rtl/conv_scan_ctrl.sv
// Raster-scan sequencer: walks (i, j), strobes the address generator, waits out BRAM latency, handshakes patches.
// Optional macro CONV_SCAN_ROW_PRIME_EN: double addr_gen strobe at the first column of every row.
module conv_scan_ctrl #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       patch_ready,
  output logic [4:0] i,
  output logic [4:0] j,
  output logic       addr_gen,
  output logic       patch_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_PRIME, S_WAIT, S_HOLD, S_DONE
  } state_t;

  localparam logic [4:0] W_LAST = 5'(IMG_W - 1);
  localparam logic [4:0] H_LAST = 5'(IMG_H - 1);
  localparam logic [3:0] LAT    = 4'(RD_LAT);

  state_t     r_state, w_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [4:0] r_i, r_j, w_i_nxt, w_j_nxt;
  logic       r_addr_gen, r_patch_valid, r_busy, r_done;
  logic       w_prime;

`ifdef CONV_SCAN_ROW_PRIME_EN
  // The generator needs an extra strobe to register the row change before its window load.
  assign w_prime = (r_j == 5'd0);
`else
  assign w_prime = 1'b0;
`endif

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_i_nxt   = r_i;
    w_j_nxt   = r_j;
    case (r_state)
      S_IDLE: if (start) begin
        w_nxt   = S_ISSUE;
        w_i_nxt = 5'd0;
        w_j_nxt = 5'd0;
      end
      S_ISSUE: begin
        if (w_prime) begin
          w_nxt = S_PRIME;
        end else begin
          w_nxt     = S_WAIT;
          w_cnt_nxt = LAT;
        end
      end
      S_PRIME: begin
        w_nxt     = S_WAIT;
        w_cnt_nxt = LAT;
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_nxt = S_HOLD;
      end
      S_HOLD: if (patch_ready) begin
        if (r_j < W_LAST) begin
          w_j_nxt = r_j + 5'd1;
          w_nxt   = S_ISSUE;
        end else if (r_i < H_LAST) begin
          w_j_nxt = 5'd0;
          w_i_nxt = r_i + 5'd1;
          w_nxt   = S_ISSUE;
        end else begin
          w_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_nxt   = S_IDLE;
        w_i_nxt = 5'd0;
        w_j_nxt = 5'd0;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_i           <= 5'd0;
      r_j           <= 5'd0;
      r_addr_gen    <= 1'b0;
      r_patch_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_nxt;
      r_cnt         <= w_cnt_nxt;
      r_i           <= w_i_nxt;
      r_j           <= w_j_nxt;
      r_addr_gen    <= (w_nxt == S_ISSUE) || (w_nxt == S_PRIME);
      r_patch_valid <= (w_nxt == S_HOLD);
      r_busy        <= (w_nxt != S_IDLE);
      r_done        <= (w_nxt == S_DONE);
    end
  end

  assign i           = r_i;
  assign j           = r_j;
  assign addr_gen    = r_addr_gen;
  assign patch_valid = r_patch_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Directed bench for conv_scan_ctrl: full 28x28 scan, backpressure, stray start, async reset, RD_LAT 1/15 on 2x2 maps.
module tb_conv_scan_ctrl;

`ifdef CONV_SCAN_ROW_PRIME_EN
  localparam int EXP_AG  = 812;
  localparam int EXP_J0  = 56;
  localparam int EXP_CYC = 3164;
`else
  localparam int EXP_AG  = 784;
  localparam int EXP_J0  = 28;
  localparam int EXP_CYC = 3136;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_m = 1'b0, ready_m = 1'b1;
  logic start_s = 1'b0, ready_s = 1'b1;

  logic [4:0] m_i, m_j, a_i, a_j, b_i, b_j;
  logic m_ag, m_pv, m_busy, m_done;
  logic a_ag, a_pv, a_busy, a_done;
  logic b_ag, b_pv, b_busy, b_done;

  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  conv_scan_ctrl #(.IMG_W(28), .IMG_H(28), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start_m), .patch_ready(ready_m),
    .i(m_i), .j(m_j), .addr_gen(m_ag), .patch_valid(m_pv), .busy(m_busy), .done(m_done));

  conv_scan_ctrl #(.IMG_W(2), .IMG_H(2), .RD_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .start(start_s), .patch_ready(ready_s),
    .i(a_i), .j(a_j), .addr_gen(a_ag), .patch_valid(a_pv), .busy(a_busy), .done(a_done));

  conv_scan_ctrl #(.IMG_W(2), .IMG_H(2), .RD_LAT(15)) dut_l15 (
    .clk(clk), .rst(rst), .start(start_s), .patch_ready(ready_s),
    .i(b_i), .j(b_j), .addr_gen(b_ag), .patch_valid(b_pv), .busy(b_busy), .done(b_done));

  // Monitor on the main instance: strobe/acceptance/done counts plus raster-order model.
  logic mon_clr = 1'b0;
  int ag_cnt, ag_j0, acc_cnt, done_cnt, ord_err, exp_i, exp_j;
  always @(negedge clk) begin
    if (mon_clr) begin
      ag_cnt = 0; ag_j0 = 0; acc_cnt = 0; done_cnt = 0; ord_err = 0; exp_i = 0; exp_j = 0;
    end else begin
      if (m_ag) begin
        ag_cnt++;
        if (m_j == 5'd0) ag_j0++;
      end
      if (m_pv && ready_m) begin
        if (int'(m_i) != exp_i || int'(m_j) != exp_j) ord_err++;
        acc_cnt++;
        if (exp_j == 27) begin exp_j = 0; exp_i++; end
        else exp_j++;
      end
      if (m_done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start_m();
    @(posedge clk); #1 start_m = 1'b1; mon_clr = 1'b1;
    @(posedge clk); #1 start_m = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic wait_ag_at(input int wi, input int wj, output bit hit);
    hit = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (m_ag && int'(m_i) == wi && int'(m_j) == wj) begin hit = 1'b1; break; end
    end
  endtask

  initial begin
    int first_ag, done_at, busy1, last_a, last_b, na, nb;
    bit hit, pa, pb, da, db;
    int pos_a [4];

    // Reset state
    #3 rst = 1'b0;
    #9;
    chk("rst_i", m_i, 0); chk("rst_j", m_j, 0); chk("rst_ag", m_ag, 0);
    chk("rst_pv", m_pv, 0); chk("rst_busy", m_busy, 0); chk("rst_done", m_done, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Full scan, ready tied high
    pulse_start_m();
    first_ag = -1; done_at = -1; busy1 = 0;
    for (int k = 1; k <= 6000; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = m_busy;
      if (m_ag && first_ag < 0) first_ag = k;
      if (m_done) begin done_at = k; break; end
    end
    chk("first_ag_cycle", first_ag, 1);
    chk("busy_after_start", busy1, 1);
    chk("scan_cycles", done_at - first_ag, EXP_CYC);
    chk("done_busy", m_busy, 1);
    @(negedge clk);
    chk("post_done", m_done, 0); chk("post_busy", m_busy, 0);
    chk("post_i", m_i, 0); chk("post_j", m_j, 0);
    chk("acceptances", acc_cnt, 784);
    chk("ag_cycles", ag_cnt, EXP_AG);
    chk("ag_j0_cycles", ag_j0, EXP_J0);
    chk("done_pulses", done_cnt, 1);
    chk("raster_order", ord_err, 0);

    // Stray start at (2,2), backpressure at (3,27)
    pulse_start_m();
    wait_ag_at(2, 2, hit);
    chk("reach_2_2", hit, 1);
    @(posedge clk); #1 start_m = 1'b1;
    @(posedge clk); #1 start_m = 1'b0;
    wait_ag_at(3, 27, hit);
    chk("reach_3_27", hit, 1);
    @(posedge clk); #1 ready_m = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_pv) begin hit = 1'b1; break; end
    end
    chk("bp_pv_rise", hit, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_pv", m_pv, 1); chk("bp_i", m_i, 3); chk("bp_j", m_j, 27);
    end
    @(posedge clk); #1 ready_m = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_ag) begin hit = 1'b1; break; end
    end
    chk("bp_next_ag", hit, 1);
    chk("bp_next_i", m_i, 4); chk("bp_next_j", m_j, 0);
    hit = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (!m_busy) begin hit = 1'b1; break; end
    end
    chk("bp_scan_end", hit, 1);
    chk("bp_done_pulses", done_cnt, 1);
    chk("bp_acceptances", acc_cnt, 784);
    chk("bp_order", ord_err, 0);

    // Async reset during WAIT at (10,5)
    pulse_start_m();
    wait_ag_at(10, 5, hit);
    chk("reach_10_5", hit, 1);
    @(negedge clk);
    chk("wait_busy", m_busy, 1); chk("wait_ag", m_ag, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_i", m_i, 0); chk("arst_j", m_j, 0); chk("arst_ag", m_ag, 0);
    chk("arst_pv", m_pv, 0); chk("arst_busy", m_busy, 0); chk("arst_done", m_done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_done", done_cnt, 0);
    chk("arst_idle", m_busy, 0);
    pulse_start_m();
    @(negedge clk);
    chk("restart_ag", m_ag, 1); chk("restart_i", m_i, 0); chk("restart_j", m_j, 0);

    // RD_LAT=1 and RD_LAT=15 on 2x2 maps
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    last_a = 0; last_b = 0; na = 0; nb = 0; pa = 0; pb = 0; da = 0; db = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (a_ag) last_a = k;
      if (b_ag) last_b = k;
      if (a_pv && !pa) chk("lat_rd1", k - last_a, 2);
      if (b_pv && !pb) chk("lat_rd15", k - last_b, 16);
      if (a_pv) begin
        if (na < 4) pos_a[na] = int'({a_i, a_j});
        na++;
      end
      if (b_pv) nb++;
      pa = a_pv; pb = b_pv;
      if (a_done) da = 1'b1;
      if (b_done) db = 1'b1;
      if (da && db) break;
    end
    chk("small_done_rd1", da, 1);
    chk("small_done_rd15", db, 1);
    chk("positions_rd1", na, 4);
    chk("positions_rd15", nb, 4);
    chk("pos0", pos_a[0], 0);
    chk("pos1", pos_a[1], 1);
    chk("pos2", pos_a[2], 32);
    chk("pos3", pos_a[3], 33);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
